fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the femtoRV32 core. Holds the program counter, drives the word address of the combinational instruction memory, and captures the returned instruction into an IF/ID pipeline register with a valid/ready handshake toward decode. Accepts branch/jump redirects from the execute stage, squashing the in-flight instruction. Enters a fault state when a redirect target is not word-aligned.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 6, instruction memory word-address width (64 words).
- NOP_INST, 32'h0000_0013, value placed in id_inst on reset and on squash (ADDI x0,x0,0).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target byte address.
- id_ready  in  1  decode accepts id_* this cycle.
- id_valid  out  1  id_* holds a live instruction.
- id_inst  out  32  captured instruction.
- id_pc  out  32  byte PC of id_inst.
- id_pc_plus4  out  32  id_pc + 4 (link value for JAL/JALR).
- fetch_pc  out  32  current PC register.
- fault  out  1  misaligned redirect seen; sticky until reset.
- fetch_cnt  out  32  count of instructions handed to decode.

## Operation
- FSM states: RUN, FAULT. Reset enters RUN. RUN→FAULT on redirect_valid with redirect_pc[1:0] != 0. FAULT exits only via rst_n.
- Transfer = id_valid && id_ready. Advance = !id_valid || id_ready.
- RUN, per rising edge, priority order:
  - redirect_valid, aligned: pc <= redirect_pc; id_valid <= 0; id_inst <= NOP_INST. Applies regardless of id_ready; the instruction fetched this cycle is discarded.
  - redirect_valid, misaligned: pc unchanged; id_valid <= 0; id_inst <= NOP_INST; state <= FAULT; fault <= 1.
  - else if advance: id_inst <= imem_data; id_pc <= pc; id_pc_plus4 <= pc + 4; id_valid <= 1; pc <= pc + 4.
  - else (stall): all registers hold.
- FAULT: pc frozen; redirect_valid ignored; no new capture. If id_valid is already 0, it stays 0. If id_valid is 1 when the fault is entered it is cleared by the same edge, so no instruction is delivered after entry.
- fetch_cnt increments by 1 on every transfer, including the transfer coinciding with a redirect edge. It wraps modulo 2^32.
- PC arithmetic is 32-bit, modulo 2^32. imem_addr uses only pc[ADDR_W+1:2], so fetch past word 2^ADDR_W-1 wraps to word 0. id_pc keeps full 32-bit values.

## Timing
- Reset values (asynchronous): pc = RESET_PC; id_valid = 0; id_inst = NOP_INST; id_pc = 0; id_pc_plus4 = 0; fault = 0; fetch_cnt = 0; state = RUN.
- imem_addr is purely combinational from pc. The memory read completes in the same cycle.
- Latency: the instruction at pc appears on id_* one edge after pc is presented. Sustained throughput is 1 instruction/cycle when id_ready = 1.
- Redirect penalty: if the redirect is sampled at edge k, id_valid = 0 after edge k, and the target instruction is valid after edge k+1 (one bubble).
- Redirect during a stall (id_valid = 1, id_ready = 0) still squashes id_*. The held instruction is never transferred.
- Deassertion of rst_n mid-operation is sampled at the next edge; the first capture occurs at the first edge after release.

## Test plan
- Reset/startup: ROM mem[0] = 0x00500093, mem[1] = 0x00308113, id_ready = 1; release rst_n -> before the first edge, id_valid = 0 and id_inst = 0x00000013. After edge 1: id_inst = 0x00500093, id_pc = 0, id_pc_plus4 = 4. After edge 2: id_inst = 0x00308113, id_pc = 4, fetch_cnt = 1.
- Stall: id_ready = 0 for 3 cycles while id_pc = 8 -> id_*, fetch_pc = 12 and fetch_cnt hold. After id_ready = 1, id_pc advances to 12.
- Redirect: at fetch_pc = 16, pulse redirect_valid with redirect_pc = 40 -> the next cycle shows id_valid = 0; the one after shows id_pc = 40 and id_inst = mem[10].
- Redirect during stall: with id_valid = 1 and id_ready = 0, redirect to 0 -> id_valid drops, fetch_cnt unchanged, then id_pc = 0.
- Misaligned: redirect_pc = 0x0000000A -> fault = 1, id_valid = 0 thereafter, fetch_pc frozen. A later aligned redirect is ignored. rst_n clears fault.
- Wrap: redirect to 252 -> id_pc = 252 (imem_addr 63), then id_pc = 256 with id_inst = mem[0].

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the femtoRV32 core.
// Holds the PC, addresses a combinational instruction ROM, and registers the
// fetched word into the IF/ID pipeline register with a valid/ready handshake.
// Execute-stage redirects squash the in-flight instruction. A misaligned
// redirect target freezes the stage in FAULT until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_inst,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4,
    output logic [31:0]       fetch_pc,
    output logic              fault,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus4_q;
    logic        fault_q;
    logic [31:0] fetch_cnt_q;

    logic transfer;
    logic advance;
    logic misaligned;

    // Handshake qualifiers: a transfer hands id_* to decode; advance means the
    // pipeline register is free to take the word currently on imem_data.
    assign transfer   = id_valid_q && id_ready;
    assign advance    = !id_valid_q || id_ready;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // The ROM is word addressed; bits above the ROM size are ignored, so the
    // fetch address wraps while the full byte PC keeps counting.
    assign imem_addr   = pc_q[ADDR_W+1:2];

    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fetch_pc    = pc_q;
    assign fault       = fault_q;
    assign fetch_cnt   = fetch_cnt_q;

    // Fetch FSM: PC update, IF/ID capture, squash, fault entry and delivery count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            fault_q       <= 1'b0;
            fetch_cnt_q   <= 32'h0000_0000;
        end else begin
            // A transfer on the same edge as a redirect still counts: decode
            // took the instruction before the squash lands.
            if (transfer) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end

            case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        // Squash whatever is in IF/ID and drop this cycle's fetch.
                        id_valid_q <= 1'b0;
                        id_inst_q  <= NOP_INST;
                        if (misaligned) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (advance) begin
                        id_inst_q     <= imem_data;
                        id_pc_q       <= pc_q;
                        id_pc_plus4_q <= pc_q + 32'd4;
                        id_valid_q    <= 1'b1;
                        pc_q          <= pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    // Frozen: nothing new is ever delivered until reset.
                    id_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage: startup, stall, redirect,
// redirect under stall, address wrap, misaligned fault, and async reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] fetch_pc;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic [31:0] rom [64];

    int checks;
    int failures;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (6),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .fetch_pc      (fetch_pc),
        .fault         (fault),
        .fetch_cnt     (fetch_cnt)
    );

    assign imem_data = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_idpc;
        logic [31:0] e_inst;
        logic [31:0] e_fpc;
        logic        e_fault;
        logic [31:0] e_cnt;
        logic [5:0]  e_addr;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic vld, input logic [31:0] idpc, input logic [31:0] inst,
                                input logic [31:0] fpc, input logic flt, input logic [31:0] cnt,
                                input logic [5:0] addr);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_vld = vld; v.e_idpc = idpc; v.e_inst = inst; v.e_fpc = fpc;
        v.e_fault = flt; v.e_cnt = cnt; v.e_addr = addr;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | i;
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h0030_8113;

        //            rv   rpc           rdy  vld idpc  inst      fpc  flt cnt addr
        vecs[0]  = mk(0, 32'd0,        1,   1, 0,    rom[0],   4,   0,  0,  1);
        vecs[1]  = mk(0, 32'd0,        1,   1, 4,    rom[1],   8,   0,  1,  2);
        vecs[2]  = mk(0, 32'd0,        1,   1, 8,    rom[2],   12,  0,  2,  3);
        vecs[3]  = mk(0, 32'd0,        0,   1, 8,    rom[2],   12,  0,  2,  3);
        vecs[4]  = mk(0, 32'd0,        0,   1, 8,    rom[2],   12,  0,  2,  3);
        vecs[5]  = mk(0, 32'd0,        0,   1, 8,    rom[2],   12,  0,  2,  3);
        vecs[6]  = mk(0, 32'd0,        1,   1, 12,   rom[3],   16,  0,  3,  4);
        vecs[7]  = mk(1, 32'd40,       1,   0, 12,   NOP,      40,  0,  4,  10);
        vecs[8]  = mk(0, 32'd0,        1,   1, 40,   rom[10],  44,  0,  4,  11);
        vecs[9]  = mk(1, 32'd0,        0,   0, 40,   NOP,      0,   0,  4,  0);
        vecs[10] = mk(0, 32'd0,        1,   1, 0,    rom[0],   4,   0,  4,  1);
        vecs[11] = mk(1, 32'd252,      1,   0, 0,    NOP,      252, 0,  5,  63);
        vecs[12] = mk(0, 32'd0,        1,   1, 252,  rom[63],  256, 0,  5,  0);
        vecs[13] = mk(0, 32'd0,        1,   1, 256,  rom[0],   260, 0,  6,  1);
        vecs[14] = mk(1, 32'h0000_000A, 1,  0, 256,  NOP,      260, 1,  7,  1);
        vecs[15] = mk(1, 32'd40,       1,   0, 256,  NOP,      260, 1,  7,  1);
        vecs[16] = mk(0, 32'd0,        1,   0, 256,  NOP,      260, 1,  7,  1);

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset id_valid",  {31'd0, id_valid}, 32'd0);
        chk("reset id_inst",   id_inst, NOP);
        chk("reset id_pc",     id_pc, 32'd0);
        chk("reset plus4",     id_pc_plus4, 32'd0);
        chk("reset fetch_pc",  fetch_pc, 32'd0);
        chk("reset fault",     {31'd0, fault}, 32'd0);
        chk("reset fetch_cnt", fetch_cnt, 32'd0);

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].rdy;
            @(posedge clk);
            #1;
            $display("vec %0d: rv=%0d rpc=%0d rdy=%0d -> vld=%0d id_pc=%0d inst=%08h fpc=%0d fault=%0d cnt=%0d",
                     i, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, id_valid, id_pc, id_inst, fetch_pc, fault, fetch_cnt);
            chk($sformatf("v%0d id_valid", i),  {31'd0, id_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d id_pc", i),     id_pc, vecs[i].e_idpc);
            chk($sformatf("v%0d id_plus4", i),  id_pc_plus4, vecs[i].e_idpc + 32'd4);
            chk($sformatf("v%0d id_inst", i),   id_inst, vecs[i].e_inst);
            chk($sformatf("v%0d fetch_pc", i),  fetch_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d fault", i),     {31'd0, fault}, {31'd0, vecs[i].e_fault});
            chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d imem_addr", i), {26'd0, imem_addr}, {26'd0, vecs[i].e_addr});
        end

        // Asynchronous reset mid-cycle clears fault and state without an edge.
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: fault=%0d fpc=%0d vld=%0d cnt=%0d", fault, fetch_pc, id_valid, fetch_cnt);
        chk("async fault",     {31'd0, fault}, 32'd0);
        chk("async fetch_pc",  fetch_pc, 32'd0);
        chk("async id_valid",  {31'd0, id_valid}, 32'd0);
        chk("async id_inst",   id_inst, NOP);
        chk("async fetch_cnt", fetch_cnt, 32'd0);

        // Release between edges: first capture on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("post-reset edge: vld=%0d id_pc=%0d inst=%08h fpc=%0d", id_valid, id_pc, id_inst, fetch_pc);
        chk("restart id_valid", {31'd0, id_valid}, 32'd1);
        chk("restart id_inst",  id_inst, rom[0]);
        chk("restart id_pc",    id_pc, 32'd0);
        chk("restart fetch_pc", fetch_pc, 32'd4);

        // Misaligned redirect while a held instruction is stalled: it is
        // cleared by the fault edge and never transferred afterwards.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0002;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        $display("stalled fault: vld=%0d fault=%0d cnt=%0d fpc=%0d", id_valid, fault, fetch_cnt, fetch_pc);
        chk("sfault id_valid",  {31'd0, id_valid}, 32'd0);
        chk("sfault fault",     {31'd0, fault}, 32'd1);
        chk("sfault fetch_cnt", fetch_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("sfault hold vld", {31'd0, id_valid}, 32'd0);
        chk("sfault hold pc",  fetch_pc, 32'd4);
        chk("sfault hold cnt", fetch_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
